data_memory_ctrl: RTL and testbench

- Parametrised single-port synchronous data memory for the single-cycle core's load/store path.
- Generalises the fixed 16x16 data store with:
  - configurable width and depth
  - byte-lane write masks
  - a req/ready handshake with a read-valid strobe
  - a post-reset zero-fill state machine
  - defined out-of-range address behaviour
- Sits between the core's memory stage and the data array. One access per cycle.

---
 rtl/data_memory_ctrl.sv | 94 +++++++++
 tb/tb_data_memory_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with byte masks, req/ready handshake and zero-fill.
// Define DMEM_ADDR_ERR_EN to add the registered addr_err output.
module data_memory_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata
`ifdef DMEM_ADDR_ERR_EN
  ,
  output logic                    addr_err
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          in_range;
  logic          accept;
  logic [IW-1:0] idx;

  // No aliasing: anything at or past DEPTH is out of range.
  assign in_range = {1'b0, addr} < DEPTH_A;
  assign accept   = req & ready;
  assign idx      = addr[IW-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end
        end
        S_IDLE: ready <= 1'b1;
      endcase
    end
  end

  // Array has no reset; the fill walks it one word per edge.
  always_ff @(posedge clock) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= accept & ~we;
      if (accept && !we) rdata <= in_range ? mem[idx] : '0;
    end
  end

`ifdef DMEM_ADDR_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) addr_err <= 1'b0;
    else          addr_err <= accept & ~in_range;
  end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed testbench for data_memory_ctrl (default 16x16 configuration).
// Each task drives one scenario and checks outputs 1 time unit after posedge.
module tb_data_memory_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  wmask;
  logic        ready;
  logic        rvalid;
  logic [15:0] rdata;
`ifdef DMEM_ADDR_ERR_EN
  logic        addr_err;
`endif

  int errors = 0;
  int checks = 0;

  data_memory_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .wmask   (wmask),
    .ready   (ready),
    .rvalid  (rvalid),
    .rdata   (rdata)
`ifdef DMEM_ADDR_ERR_EN
    ,
    .addr_err(addr_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    req = r; we = w; addr = a; wdata = d; wmask = m;
  endtask

  // Release reset with req=1 we=0 addr=0 and watch the 16-edge fill.
  task automatic release_and_fill(input string tag);
    drive(1'b1, 1'b0, 16'd0, 16'h0, 2'b00);
    reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (ready !== (e == 16)) begin
        errors++;
        $display("FAIL %s ready edge %0d: got %b want %b", tag, e, ready, (e == 16));
      end
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s rvalid edge %0d: got %b want 0", tag, e, rvalid);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 16'd0, 16'h0, 2'b00);
    #3;
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rvalid=%b rdata=%h want 0/0/0000",
               ready, rvalid, rdata);
    end
    tick();
    tick();
    release_and_fill("fill");
    for (int i = 0; i < 16; i++) begin
      addr = 16'(i);
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
        errors++;
        $display("FAIL cleared_read[%0d]: rvalid=%b rdata=%h want 1/0000", i, rvalid, rdata);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 16'd3, 16'hBEEF, 2'b11);
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_rvalid: got %b want 0", rvalid);
    end
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_beef: rvalid=%b rdata=%h want 1/beef", rvalid, rdata);
    end
    drive(1'b0, 1'b0, 16'd0, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rvalid: got %b want 0", rvalid);
    end
  endtask

  task automatic test_byte_mask();
    drive(1'b1, 1'b1, 16'd3, 16'h1234, 2'b01);
    tick();
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'hBE34) begin
      errors++;
      $display("FAIL mask01: rvalid=%b rdata=%h want 1/be34", rvalid, rdata);
    end
    drive(1'b1, 1'b1, 16'd3, 16'h5678, 2'b00);
    tick();
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'hBE34) begin
      errors++;
      $display("FAIL mask00: rvalid=%b rdata=%h want 1/be34", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'hBE34) begin
      errors++;
      $display("FAIL b2b_first: rvalid=%b rdata=%h want 1/be34", rvalid, rdata);
    end
    addr = 16'd4;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_second: rvalid=%b rdata=%h want 1/0000", rvalid, rdata);
    end
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rvalid !== 1'b0 || rdata !== 16'h0000) begin
        errors++;
        $display("FAIL hold_zero[%0d]: rvalid=%b rdata=%h want 0/0000", k, rvalid, rdata);
      end
    end
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    drive(1'b1, 1'b1, 16'd5, 16'hAAAA, 2'b11);
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 16'hBE34) begin
      errors++;
      $display("FAIL hold_on_write: rvalid=%b rdata=%h want 0/be34", rvalid, rdata);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 16'd20, 16'hFFFF, 2'b11);
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_wr_rvalid: got %b want 0", rvalid);
    end
`ifdef DMEM_ADDR_ERR_EN
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_wr_err: got %b want 1", addr_err);
    end
`endif
    drive(1'b1, 1'b0, 16'd20, 16'h0, 2'b00);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL oor_rd: rvalid=%b rdata=%h want 1/0000", rvalid, rdata);
    end
`ifdef DMEM_ADDR_ERR_EN
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_rd_err: got %b want 1", addr_err);
    end
`endif
    addr = 16'd4;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL no_alias: rvalid=%b rdata=%h want 1/0000", rvalid, rdata);
    end
`ifdef DMEM_ADDR_ERR_EN
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL in_range_err: got %b want 0", addr_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_pending_rd: ready=%b rvalid=%b rdata=%h want 0/0/0000",
               ready, rvalid, rdata);
    end
    tick();
    release_and_fill("refill");
    // Reset again once the fill counter has reached 5.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: ready=%b rvalid=%b rdata=%h want 0/0/0000",
               ready, rvalid, rdata);
    end
    tick();
    release_and_fill("restart");
    addr = 16'd3;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL post_clear_rd: rvalid=%b rdata=%h want 1/0000", rvalid, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
